// File: rtl/pix_wr_arb_pkg.sv
// pix_wr_arb_pkg: shared state encoding, pixel field widths and beat-limit default.
package pix_wr_arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
  localparam int COORD_W     = 8;
  localparam int COL_W       = 3;
  localparam int CNT_W       = 9;
  localparam int MAXBEAT_DEF = 256;
endpackage

// File: rtl/pix_wr_arb_pick.sv
// pix_rr_pick: first valid requester at or above ptr_i, wrapping modulo NREQ.
module pix_rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [1:0]      ptr_i,
  output logic [1:0]      idx_o,
  output logic            found_o
);
  logic [1:0] j;
  always_comb begin
    idx_o   = '0;
    j       = '0;
    found_o = |valid_i;
    // scanning downward lets the nearest candidate overwrite farther ones
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = 2'((int'(ptr_i) + k) % NREQ);
      if (valid_i[j]) idx_o = j;
    end
  end
endmodule

// File: rtl/pix_wr_arb.sv
// pix_wr_arb: round-robin arbiter for pixel-write bursts into a framebuffer port.
// Define PIX_WR_ARB_FIXPRIO_EN for fixed priority (lowest index wins, PTR held at 0).
module pix_wr_arb
  import pix_wr_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int MAXBEAT = MAXBEAT_DEF
) (
  input  logic                    clk_i,
  input  logic                    nrst_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ-1:0]         req_last_i,
  input  logic [COORD_W*NREQ-1:0] req_x_i,
  input  logic [COORD_W*NREQ-1:0] req_y_i,
  input  logic [COL_W*NREQ-1:0]   req_r_i,
  input  logic [COL_W*NREQ-1:0]   req_g_i,
  input  logic [COL_W*NREQ-1:0]   req_b_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic                    stall_i,
  output logic                    we_o,
  output logic [COORD_W-1:0]      x_o,
  output logic [COORD_W-1:0]      y_o,
  output logic [COL_W-1:0]        r_o,
  output logic [COL_W-1:0]        g_o,
  output logic [COL_W-1:0]        b_o,
  output logic [1:0]              gnt_id_o,
  output logic                    busy_o
);
  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d, gnt_q, gnt_d, pick;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found, acc, rel, we_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COL_W-1:0]   r_q, g_q, b_q;

  pix_rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i(req_valid_i),
    .ptr_i  (ptr_q),
    .idx_o  (pick),
    .found_o(found)
  );

  always_comb begin
    acc         = state_q == GRANT && req_valid_i[gnt_q] && !stall_i;
    rel         = acc && (req_last_i[gnt_q] || cnt_q == CNT_W'(MAXBEAT - 1));
    req_ready_o = (state_q == GRANT && !stall_i) ? NREQ'(1) << gnt_q : '0;
    state_d     = state_q == IDLE ? (found ? GRANT : IDLE) : (rel ? IDLE : GRANT);
    gnt_d       = (state_q == IDLE && found) ? pick : gnt_q;
    cnt_d       = state_q == IDLE ? '0 :
                  (acc && cnt_q != CNT_W'(MAXBEAT)) ? cnt_q + 1'b1 : cnt_q;
`ifdef PIX_WR_ARB_FIXPRIO_EN
    ptr_d       = '0;
`else
    ptr_d       = rel ? (int'(gnt_q) == NREQ - 1 ? 2'd0 : gnt_q + 2'd1) : ptr_q;
`endif
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      we_q    <= acc;
      if (acc) begin
        x_q <= req_x_i[gnt_q*COORD_W +: COORD_W];
        y_q <= req_y_i[gnt_q*COORD_W +: COORD_W];
        r_q <= req_r_i[gnt_q*COL_W +: COL_W];
        g_q <= req_g_i[gnt_q*COL_W +: COL_W];
        b_q <= req_b_i[gnt_q*COL_W +: COL_W];
      end
    end
  end

  assign we_o     = we_q;
  assign x_o      = x_q;
  assign y_o      = y_q;
  assign r_o      = r_q;
  assign g_o      = g_q;
  assign b_o      = b_q;
  assign gnt_id_o = gnt_q;
  assign busy_o   = state_q == GRANT;
endmodule

// File: tb/tb_pix_wr_arb.sv
// tb_pix_wr_arb: directed scenarios with a write scoreboard; also valid with PIX_WR_ARB_FIXPRIO_EN.
module tb_pix_wr_arb;
  localparam int N = 3;
  typedef struct packed {
    logic [7:0] x, y;
    logic [2:0] r, g, b;
    logic       last;
  } beat_t;

  logic clk = 1'b0, nrst = 1'b1, stall = 1'b0;
  logic [N-1:0] valid = '0, last = '0, ready;
  logic [8*N-1:0] rx = '0, ry = '0;
  logic [3*N-1:0] rr = '0, rg = '0, rb = '0;
  logic we, busy;
  logic [7:0] x, y;
  logic [2:0] r, g, b;
  logic [1:0] gid;

  beat_t       src_q[N][$];
  logic [26:0] exp_q[$];
  int n_assert = 0, n_fail = 0, cyc = 0, last_we = -1;
  bit chk_gap = 0;

  always #5 clk = ~clk;

  pix_wr_arb #(.NREQ(N), .MAXBEAT(256)) dut (
    .clk_i(clk), .nrst_i(nrst), .req_valid_i(valid), .req_last_i(last),
    .req_x_i(rx), .req_y_i(ry), .req_r_i(rr), .req_g_i(rg), .req_b_i(rb),
    .req_ready_o(ready), .stall_i(stall), .we_o(we), .x_o(x), .y_o(y),
    .r_o(r), .g_o(g), .b_o(b), .gnt_id_o(gid), .busy_o(busy)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic beat_t gen(int i, int k, logic l);
    beat_t bt;
    bt.x = 8'(16 * i + k);
    bt.y = 8'(4 * i + k / 256);
    bt.r = 3'(i);
    bt.g = 3'(k);
    bt.b = 3'(k >> 3);
    bt.last = l;
    return bt;
  endfunction

  function automatic logic [26:0] ex(int i, beat_t bt);
    return {2'(i), bt.x, bt.y, bt.r, bt.g, bt.b};
  endfunction

  task automatic drive();
    beat_t bt;
    for (int i = 0; i < N; i++) begin
      valid[i] = src_q[i].size() > 0;
      bt = valid[i] ? src_q[i][0] : '0;
      rx[8*i +: 8] = bt.x;
      ry[8*i +: 8] = bt.y;
      rr[3*i +: 3] = bt.r;
      rg[3*i +: 3] = bt.g;
      rb[3*i +: 3] = bt.b;
      last[i] = bt.last;
    end
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    logic [26:0] e;
    #1;
    acc = valid & ready;
    if (stall) chk("stall_ready", 32'(ready), 0);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (acc[i]) void'(src_q[i].pop_front());
    if (we) begin
      if (exp_q.size() == 0) chk("unexpected_we", 32'(we), 0);
      else begin
        e = exp_q.pop_front();
        chk("beat", 32'({gid, x, y, r, g, b}), 32'(e));
      end
      if (chk_gap && last_we >= 0) chk("we_gap", 32'(cyc - last_we), 2);
      last_we = cyc;
    end
    drive();
  endtask

  task automatic reset_dut();
    nrst = 1'b0;
    #1;
    chk("rst_out", 32'({we, busy, gid, x, y, r, g, b}), 0);
    chk("rst_ready", 32'(ready), 0);
    exp_q.delete();
    last_we = -1;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic start();
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive();
    reset_dut();
  endtask

  task automatic drain(int budget);
    for (int t = 0; t < budget && exp_q.size() > 0; t++) tick();
    chk("drain_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    beat_t bt;
    #2;
    start();
    repeat (100) begin
      tick();
      chk("idle", 32'({we, busy, ready}), 0);
    end

    start();
    for (int i = 0; i < N; i++) for (int k = 0; k < 2; k++) src_q[i].push_back(gen(i, k, 1'b1));
`ifdef PIX_WR_ARB_FIXPRIO_EN
    for (int i = 0; i < N; i++) for (int k = 0; k < 2; k++) exp_q.push_back(ex(i, gen(i, k, 1'b1)));
`else
    for (int k = 0; k < 2; k++) for (int i = 0; i < N; i++) exp_q.push_back(ex(i, gen(i, k, 1'b1)));
`endif
    drive();
    chk_gap = 1;
    drain(40);
    chk_gap = 0;

    start();
    for (int k = 0; k < 3; k++) begin
      src_q[0].push_back(gen(0, k, 1'b1));
      src_q[2].push_back(gen(2, k, 1'b1));
    end
`ifdef PIX_WR_ARB_FIXPRIO_EN
    for (int k = 0; k < 3; k++) exp_q.push_back(ex(0, gen(0, k, 1'b1)));
    for (int k = 0; k < 3; k++) exp_q.push_back(ex(2, gen(2, k, 1'b1)));
`else
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ex(0, gen(0, k, 1'b1)));
      exp_q.push_back(ex(2, gen(2, k, 1'b1)));
    end
`endif
    drive();
    drain(40);

    start();
    for (int k = 0; k < 4; k++) begin
      bt = '{x: 8'(8'h10 + k), y: 8'h20, r: 3'b101, g: 3'b101, b: 3'b101, last: k == 3};
      src_q[1].push_back(bt);
      exp_q.push_back(ex(1, bt));
    end
    drive();
    for (int t = 0; t < 30 && exp_q.size() > 0; t++) begin
      stall = t >= 2 && t <= 4;
      tick();
    end
    stall = 1'b0;
    chk("stall_drain", 32'(exp_q.size()), 0);
    chk("stall_idle", 32'(busy), 0);

    start();
    for (int k = 0; k < 8; k++) begin
      src_q[0].push_back(gen(0, k, k == 7));
      exp_q.push_back(ex(0, gen(0, k, k == 7)));
    end
    drive();
    for (int t = 0; t < 20 && src_q[0].size() > 4; t++) tick();
    chk("pre_rst_busy", 32'({busy, gid}), 32'h4);
    reset_dut();
    foreach (src_q[0][k]) exp_q.push_back(ex(0, src_q[0][k]));
    drive();
    drain(30);

    start();
    for (int k = 0; k < 300; k++) src_q[0].push_back(gen(0, k, 1'b0));
    for (int k = 0; k < 3; k++) src_q[1].push_back(gen(1, k, k == 2));
`ifdef PIX_WR_ARB_FIXPRIO_EN
    for (int k = 0; k < 300; k++) exp_q.push_back(ex(0, gen(0, k, 1'b0)));
`else
    for (int k = 0; k < 256; k++) exp_q.push_back(ex(0, gen(0, k, 1'b0)));
    for (int k = 0; k < 3; k++) exp_q.push_back(ex(1, gen(1, k, k == 2)));
    for (int k = 256; k < 300; k++) exp_q.push_back(ex(0, gen(0, k, 1'b0)));
`endif
    drive();
    drain(400);
    repeat (3) tick();
    chk("hold_grant", 32'({busy, gid}), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pix_wr_arb.md
PIX_WR_ARB -- requirements
Module: pix_wr_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, giving the number of pixel-write requesters (2..4).
REQ-002 The block SHALL have parameter MAXBEAT, default 256, giving the beat limit per grant before forced release.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 NRST  in  1  reset, asynchronous and active-low.
REQ-005 REQ_VALID  in  NREQ  per-requester beat valid.
REQ-006 REQ_LAST  in  NREQ  per-requester last beat of burst.
REQ-007 REQ_X, REQ_Y  in  8*NREQ each  per-requester pixel coordinate; requester i occupies bits [8i+7:8i].
REQ-008 REQ_R, REQ_G, REQ_B  in  3*NREQ each  per-requester colour; requester i occupies bits [3i+2:3i].
REQ-009 REQ_READY  out  NREQ  per-requester beat accept.
REQ-010 STALL  in  1  framebuffer busy, e.g. scan-out; while high, no beat is accepted.
REQ-011 WE  out  1  framebuffer write strobe.
REQ-012 X, Y  out  8 each  framebuffer write address, pixel index {Y,X}.
REQ-013 R, G, B  out  3 each  framebuffer write colour.
REQ-014 GNT_ID  out  2  index of the current or most recent grantee.
REQ-015 BUSY  out  1  high while the arbiter is in the GRANT state.

Function
REQ-016 The block SHALL implement states IDLE and GRANT.
REQ-017 IDLE: if any REQ_VALID is high, the block SHALL select a winner, load GNT_ID, clear the beat counter and enter GRANT next cycle; REQ_READY SHALL be all zero in IDLE, giving 1 cycle arbitration latency.
REQ-018 Winner selection SHALL be round-robin: search upward from pointer PTR, modulo NREQ; the first valid requester wins.
REQ-019 In GRANT, REQ_READY[GNT_ID] SHALL equal ~STALL, and all other ready bits SHALL be 0; a beat is accepted when REQ_VALID[GNT_ID] and REQ_READY[GNT_ID] are both high.
REQ-020 An accepted beat SHALL appear registered on X/Y/R/G/B with WE=1 exactly one cycle after acceptance; WE=0 otherwise; X/Y/R/G/B SHALL hold their values when WE=0.
REQ-021 The beat counter SHALL be 9 bits, increment per accepted beat and saturate at MAXBEAT.
REQ-022 GRANT SHALL return to IDLE after an accepted beat with REQ_LAST high, or after an accepted beat that brings the count to MAXBEAT; PTR SHALL then become (GNT_ID+1) mod NREQ.
REQ-023 A grantee dropping REQ_VALID mid-burst SHALL keep the grant; no timeout applies.
REQ-024 STALL high SHALL freeze the counter and state; beats resume unchanged when STALL falls.
REQ-025 A single-beat burst (VALID and LAST in the same beat) SHALL take 2 cycles from IDLE to IDLE.
REQ-026 Requests arriving in the same cycle as a release SHALL be arbitrated in the following IDLE cycle using the updated PTR.

Reset
REQ-027 On NRST low, the block SHALL immediately set state=IDLE, PTR=0, GNT_ID=0, counter=0, WE=0, X=Y=0, R=G=B=0, REQ_READY=0 and BUSY=0, regardless of any burst in progress.
REQ-028 After NRST rises, the first arbitration SHALL occur no earlier than the first rising clock edge.

Configuration
REQ-029 With macro PIX_WR_ARB_FIXPRIO_EN defined, winner selection SHALL be fixed priority (lowest index wins), and PTR SHALL be unused and stay 0.
REQ-030 With PIX_WR_ARB_FIXPRIO_EN undefined, round-robin per REQ-018 SHALL apply.

Structure
REQ-031 A shared package SHALL hold the state encodings (IDLE=0, GRANT=1), the pixel field widths (coordinate 8, colour 3) and the MAXBEAT default.
REQ-032 Winner selection SHALL be a sub-module pix_rr_pick, with inputs valid vector and PTR and output winner index plus a found flag.

Verification
REQ-033 Reset mid-burst: NRST low during beat 5 of a req0 burst -> WE=0 and all outputs 0 the same cycle; req0 is re-granted afresh after release.
REQ-034 Round-robin: req0..req2 VALID continuously with 1-beat bursts -> GNT_ID sequence 0,1,2,0,1,2; WE every second cycle.
REQ-035 Stall: req1 burst X=0x10..0x13, Y=0x20, colour 3'b101, STALL high for cycles 2..4 -> 4 WE pulses, addresses in order, none lost or duplicated.
REQ-036 MAXBEAT: req0 streams 300 beats with LAST low and req1 VALID -> release after beat 256; req1 granted next; req0 regains the grant after req1's LAST.
REQ-037 Fixed priority (macro defined): req0 and req2 both always VALID with 1-beat bursts -> GNT_ID stays 0; req2 is never granted.
REQ-038 Idle: no VALID for 100 cycles -> WE=0, BUSY=0 and REQ_READY=0 throughout.
